// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 scan-code sequencer: prefix bytes, FSM encoding,
// key-event record and the per-frame decode step.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } ps2_state_e;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       make;
    } key_evt_t;

    typedef struct packed {
        ps2_state_e nxt;
        logic       emit;
        logic       err;
        key_evt_t   evt;
    } ps2_step_t;

    // Outcome of accepting one frame in a given prefix state.
    function automatic ps2_step_t ps2_decode(input ps2_state_e state, input logic [7:0] data);
        ps2_step_t s;
        logic      is_ext;
        logic      is_brk;
        is_ext      = (data == PS2_EXT);
        is_brk      = (data == PS2_BRK);
        s.nxt       = ST_IDLE;
        s.emit      = 1'b0;
        s.err       = 1'b0;
        s.evt.code  = data;
        s.evt.ext   = 1'b0;
        s.evt.make  = 1'b1;
        case (state)
            ST_IDLE: begin
                if (is_ext)      s.nxt = ST_EXT;
                else if (is_brk) s.nxt = ST_BRK;
                else             s.emit = 1'b1;
            end
            ST_EXT: begin
                if (is_brk) begin
                    s.nxt = ST_EXT_BRK;
                end else if (is_ext) begin
                    s.nxt = ST_EXT;
                    s.err = 1'b1;
                end else begin
                    s.emit    = 1'b1;
                    s.evt.ext = 1'b1;
                end
            end
            ST_BRK: begin
                if (is_ext || is_brk) begin
                    s.err = 1'b1;
                end else begin
                    s.emit     = 1'b1;
                    s.evt.make = 1'b0;
                end
            end
            default: begin
                if (is_ext || is_brk) begin
                    s.err = 1'b1;
                end else begin
                    s.emit     = 1'b1;
                    s.evt.ext  = 1'b1;
                    s.evt.make = 1'b0;
                end
            end
        endcase
        return s;
    endfunction

endpackage

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code sequencer: resolves E0/F0 prefixes into key events, tracks the
// held key and press count, and flags abandoned or malformed prefix sequences.
module ps2_key_ctrl
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1000000,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frm_valid,
    input  logic [7:0]       frm_data,
    output logic             frm_ready,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_make,
    output logic             key_down,
    output logic [7:0]       cur_code,
    output logic             cur_ext,
    output logic [CNT_W-1:0] press_cnt,
    output logic             seq_err
);

    localparam int               TMO_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    ps2_state_e       state;
    logic [TMO_W-1:0] tmo_cnt;
    ps2_step_t        step;
    logic             accept;
    logic             is_repeat;
    logic             is_match;

    // A frame can only be taken when the event slot is empty or draining this cycle.
    assign frm_ready = !evt_valid || evt_ready;
    assign accept    = frm_valid && frm_ready;
    assign step      = ps2_decode(state, frm_data);
    assign is_match  = (step.evt.code == cur_code) && (step.evt.ext == cur_ext);
    assign is_repeat = key_down && is_match;

    // NOTE: reset is sampled on the clock edge, so it lives inside this block rather
    // than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tmo_cnt   <= '0;
            evt_valid <= 1'b0;
            evt_code  <= '0;
            evt_ext   <= 1'b0;
            evt_make  <= 1'b0;
            key_down  <= 1'b0;
            cur_code  <= '0;
            cur_ext   <= 1'b0;
            press_cnt <= '0;
            seq_err   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let a later load in this block override
            // the drain below, so a new event can replace the one being consumed.
            if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end

            if (accept) begin
                state   <= step.nxt;
                tmo_cnt <= '0;
                if (step.err) begin
                    seq_err <= 1'b1;
                end
                if (step.emit) begin
                    evt_valid <= 1'b1;
                    evt_code  <= step.evt.code;
                    evt_ext   <= step.evt.ext;
                    evt_make  <= step.evt.make;
                    if (step.evt.make) begin
                        // Typematic repeats still produce events but leave held state alone.
                        if (!is_repeat) begin
                            cur_code  <= step.evt.code;
                            cur_ext   <= step.evt.ext;
                            key_down  <= 1'b1;
                            press_cnt <= press_cnt + CNT_W'(1);
                        end
                    end else if (is_match) begin
                        key_down <= 1'b0;
                    end
                end
            end else if (state != ST_IDLE) begin
                if (tmo_cnt == TMO_LAST) begin
                    state   <= ST_IDLE;
                    tmo_cnt <= '0;
                    seq_err <= 1'b1;
                end else begin
                    tmo_cnt <= tmo_cnt + TMO_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: prefix decoding, held-key tracking, backpressure,
// prefix timeout, illegal sequences, reset mid-sequence and press-counter wrap.
module tb_ps2_key_ctrl;
    import ps2_pkg::*;

    localparam int TMO = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frm_valid = 1'b0;
    logic [7:0] frm_data = 8'h00;
    logic       evt_ready = 1'b1;
    logic       frm_ready, evt_valid, evt_ext, evt_make, key_down, cur_ext, seq_err;
    logic [7:0] evt_code, cur_code, press_cnt;

    logic       frm_ready_2, evt_valid_2, evt_ext_2, evt_make_2, key_down_2, cur_ext_2, seq_err_2;
    logic [7:0] evt_code_2, cur_code_2;
    logic [1:0] press_cnt_2;

    int errors = 0;
    int checks = 0;

    ps2_key_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .frm_valid(frm_valid), .frm_data(frm_data),
        .frm_ready(frm_ready), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_code(evt_code), .evt_ext(evt_ext), .evt_make(evt_make),
        .key_down(key_down), .cur_code(cur_code), .cur_ext(cur_ext),
        .press_cnt(press_cnt), .seq_err(seq_err)
    );

    ps2_key_ctrl #(.TIMEOUT_CYC(TMO), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .frm_valid(frm_valid), .frm_data(frm_data),
        .frm_ready(frm_ready_2), .evt_valid(evt_valid_2), .evt_ready(evt_ready),
        .evt_code(evt_code_2), .evt_ext(evt_ext_2), .evt_make(evt_make_2),
        .key_down(key_down_2), .cur_code(cur_code_2), .cur_ext(cur_ext_2),
        .press_cnt(press_cnt_2), .seq_err(seq_err_2)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        frm_valid = 1'b0;
        evt_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Present one frame for exactly one edge; returns #1 after that edge.
    task automatic send(input logic [7:0] d);
        @(negedge clk);
        frm_valid = 1'b1;
        frm_data  = d;
        @(posedge clk);
        #1;
        frm_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({evt_valid, evt_code, evt_ext, evt_make, key_down, cur_code, cur_ext, press_cnt, seq_err} !== 30'd0) begin
            errors++;
            $display("FAIL reset_outputs: got ev=%b code=%h ext=%b mk=%b kd=%b cur=%h cx=%b cnt=%0d err=%b, expected all 0",
                     evt_valid, evt_code, evt_ext, evt_make, key_down, cur_code, cur_ext, press_cnt, seq_err);
        end
        checks++;
        if (frm_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_frm_ready: got %b expected 1", frm_ready);
        end
    endtask

    task automatic test_basic();
        do_reset();
        send(8'h1C);
        checks++;
        if ({evt_valid, evt_code, evt_ext, evt_make, key_down, press_cnt} !== {1'b1, 8'h1C, 1'b0, 1'b1, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL basic_make: got v=%b %h ext=%b mk=%b kd=%b cnt=%0d expected v=1 1c ext=0 mk=1 kd=1 cnt=1",
                     evt_valid, evt_code, evt_ext, evt_make, key_down, press_cnt);
        end
        send(8'hF0);
        checks++;
        if (evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_prefix_no_evt: got evt_valid=%b expected 0", evt_valid);
        end
        send(8'h1C);
        checks++;
        if ({evt_valid, evt_code, evt_ext, evt_make, key_down, cur_code, press_cnt} !== {1'b1, 8'h1C, 1'b0, 1'b0, 1'b0, 8'h1C, 8'd1}) begin
            errors++;
            $display("FAIL basic_break: got v=%b %h ext=%b mk=%b kd=%b cur=%h cnt=%0d expected v=1 1c ext=0 mk=0 kd=0 cur=1c cnt=1",
                     evt_valid, evt_code, evt_ext, evt_make, key_down, cur_code, press_cnt);
        end
    endtask

    task automatic test_extended();
        do_reset();
        send(8'hE0);
        send(8'h75);
        checks++;
        if ({evt_valid, evt_code, evt_ext, evt_make, key_down, cur_ext} !== {1'b1, 8'h75, 1'b1, 1'b1, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL ext_make: got v=%b %h ext=%b mk=%b kd=%b cx=%b expected v=1 75 ext=1 mk=1 kd=1 cx=1",
                     evt_valid, evt_code, evt_ext, evt_make, key_down, cur_ext);
        end
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        checks++;
        if ({evt_valid, evt_code, evt_ext, evt_make, key_down, press_cnt, seq_err} !== {1'b1, 8'h75, 1'b1, 1'b0, 1'b0, 8'd1, 1'b0}) begin
            errors++;
            $display("FAIL ext_break: got v=%b %h ext=%b mk=%b kd=%b cnt=%0d err=%b expected v=1 75 ext=1 mk=0 kd=0 cnt=1 err=0",
                     evt_valid, evt_code, evt_ext, evt_make, key_down, press_cnt, seq_err);
        end
    endtask

    task automatic test_typematic();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            send(8'h1C);
            checks++;
            if ({evt_valid, evt_code, evt_make, press_cnt} !== {1'b1, 8'h1C, 1'b1, 8'd1}) begin
                errors++;
                $display("FAIL typematic_%0d: got v=%b %h mk=%b cnt=%0d expected v=1 1c mk=1 cnt=1",
                         i, evt_valid, evt_code, evt_make, press_cnt);
            end
        end
        send(8'h32);
        checks++;
        if ({press_cnt, cur_code, key_down} !== {8'd2, 8'h32, 1'b1}) begin
            errors++;
            $display("FAIL typematic_new_key: got cnt=%0d cur=%h kd=%b expected cnt=2 cur=32 kd=1",
                     press_cnt, cur_code, key_down);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        evt_ready = 1'b0;
        send(8'h1C);
        @(negedge clk);
        frm_valid = 1'b1;
        frm_data  = 8'h32;
        checks++;
        if (frm_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_frm_ready_low: got %b expected 0", frm_ready);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({evt_valid, evt_code, evt_make, press_cnt} !== {1'b1, 8'h1C, 1'b1, 8'd1}) begin
            errors++;
            $display("FAIL bp_hold: got v=%b %h mk=%b cnt=%0d expected v=1 1c mk=1 cnt=1",
                     evt_valid, evt_code, evt_make, press_cnt);
        end
        @(negedge clk);
        evt_ready = 1'b1;
        #1;
        checks++;
        if (frm_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_frm_ready_high: got %b expected 1", frm_ready);
        end
        @(posedge clk);
        #1;
        frm_valid = 1'b0;
        evt_ready = 1'b0;
        checks++;
        if ({evt_valid, evt_code, evt_make, press_cnt, cur_code} !== {1'b1, 8'h32, 1'b1, 8'd2, 8'h32}) begin
            errors++;
            $display("FAIL bp_next_event: got v=%b %h mk=%b cnt=%0d cur=%h expected v=1 32 mk=1 cnt=2 cur=32",
                     evt_valid, evt_code, evt_make, press_cnt, cur_code);
        end
        @(negedge clk);
        evt_ready = 1'b1;
    endtask

    task automatic test_timeout();
        do_reset();
        send(8'hE0);
        repeat (TMO - 1) @(posedge clk);
        #1;
        checks++;
        if ({seq_err, dut.state} !== {1'b0, ST_EXT}) begin
            errors++;
            $display("FAIL tmo_before: got err=%b state=%0d expected err=0 state=%0d", seq_err, dut.state, ST_EXT);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({seq_err, dut.state} !== {1'b1, ST_IDLE}) begin
            errors++;
            $display("FAIL tmo_expire: got err=%b state=%0d expected err=1 state=%0d", seq_err, dut.state, ST_IDLE);
        end
        send(8'h1C);
        checks++;
        if ({evt_valid, evt_code, evt_ext, evt_make} !== {1'b1, 8'h1C, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL tmo_after_frame: got v=%b %h ext=%b mk=%b expected v=1 1c ext=0 mk=1",
                     evt_valid, evt_code, evt_ext, evt_make);
        end
        // A frame landing on the final timeout cycle takes precedence.
        do_reset();
        send(8'hE0);
        repeat (TMO - 1) @(posedge clk);
        send(8'h75);
        checks++;
        if ({evt_valid, evt_code, evt_ext, seq_err} !== {1'b1, 8'h75, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL tmo_frame_wins: got v=%b %h ext=%b err=%b expected v=1 75 ext=1 err=0",
                     evt_valid, evt_code, evt_ext, seq_err);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        send(8'hF0);
        send(8'hE0);
        checks++;
        if ({seq_err, evt_valid, dut.state} !== {1'b1, 1'b0, ST_IDLE}) begin
            errors++;
            $display("FAIL illegal_brk_ext: got err=%b v=%b state=%0d expected err=1 v=0 state=%0d",
                     seq_err, evt_valid, dut.state, ST_IDLE);
        end
        do_reset();
        send(8'hE0);
        send(8'hE0);
        send(8'h75);
        checks++;
        if ({seq_err, evt_valid, evt_code, evt_ext, evt_make} !== {1'b1, 1'b1, 8'h75, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL illegal_ext_ext: got err=%b v=%b %h ext=%b mk=%b expected err=1 v=1 75 ext=1 mk=1",
                     seq_err, evt_valid, evt_code, evt_ext, evt_make);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(8'h1C);
        send(8'hE0);
        do_reset();
        checks++;
        if ({evt_valid, evt_code, evt_ext, evt_make, key_down, cur_code, cur_ext, press_cnt, seq_err, dut.state} !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got v=%b %h kd=%b cur=%h cnt=%0d state=%0d expected all 0",
                     evt_valid, evt_code, key_down, cur_code, press_cnt, dut.state);
        end
        send(8'h1C);
        checks++;
        if ({evt_valid, evt_code, evt_ext, evt_make} !== {1'b1, 8'h1C, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL reset_mid_next: got v=%b %h ext=%b mk=%b expected v=1 1c ext=0 mk=1",
                     evt_valid, evt_code, evt_ext, evt_make);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] codes [5];
        codes = '{8'h15, 8'h16, 8'h1E, 8'h26, 8'h25};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send(codes[i]);
        end
        checks++;
        if ({press_cnt, press_cnt_2} !== {8'd5, 2'd1}) begin
            errors++;
            $display("FAIL cnt_wrap: got cnt8=%0d cnt2=%0d expected cnt8=5 cnt2=1", press_cnt, press_cnt_2);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extended();
        test_typematic();
        test_backpressure();
        test_timeout();
        test_illegal();
        test_reset_mid();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
